// File: rtl/mm_front_end_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mm_front_end_sequencer: steps one shared front_end reader across N_CH      |
// | channels, generating start/zero/last and the input-memory read address.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mm_front_end_sequencer #(
  parameter  int N_CH   = 2,
  parameter  int ADDR_W = 12,
  parameter  int SIZE_W = 12,
  parameter  int CYC_W  = 32,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic [N_CH*ADDR_W-1:0]   base,
  input  logic [N_CH*SIZE_W-1:0]   size,
  input  logic                     fe_en,
  input  logic                     fe_done,
  output logic                     fe_start,
  output logic                     fe_zero,
  output logic                     fe_last,
  output logic [ADDR_W-1:0]        addr,
  output logic [CH_W-1:0]          ch_sel,
  output logic                     busy,
  output logic                     done,
  output logic [CYC_W-1:0]         cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ISSUE   = 3'd2,
    S_RUN     = 3'd3,
    S_RELEASE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  localparam logic [CH_W-1:0]  c_last_ch = CH_W'(N_CH - 1);
  localparam logic [CYC_W-1:0] c_cyc_max = '1;

  state_t              r_state;
  state_t              w_next;
  logic [CH_W-1:0]     r_ch;
  logic [SIZE_W-1:0]   r_cnt;
  logic [CYC_W-1:0]    r_cycles;
  logic [ADDR_W-1:0]   r_base [N_CH];
  logic [SIZE_W-1:0]   r_size [N_CH];

  logic [ADDR_W-1:0]   w_base_cur;
  logic [SIZE_W-1:0]   w_size_cur;
  logic                w_at_end;
  logic                w_advance;
  logic [ADDR_W-1:0]   w_addr_sum;

  assign w_base_cur = r_base[r_ch];
  assign w_size_cur = r_size[r_ch];
  // Element counter sits on the final element; zero-length channels never get here.
  assign w_at_end   = (w_size_cur != '0) && (r_cnt == w_size_cur - SIZE_W'(1));
  assign w_advance  = fe_en && (w_size_cur != '0) && !w_at_end;
  assign w_addr_sum = w_base_cur + ADDR_W'(r_cnt);
  assign cycles     = r_cycles;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ch     <= '0;
      r_cnt    <= '0;
      r_cycles <= '0;
      for (int k = 0; k < N_CH; k++) begin
        r_base[k] <= '0;
        r_size[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < N_CH; k++) begin
              r_base[k] <= base[k*ADDR_W +: ADDR_W];
              r_size[k] <= size[k*SIZE_W +: SIZE_W];
            end
            r_ch     <= '0;
            r_cnt    <= '0;
            r_cycles <= '0;
          end
        end
        S_LOAD: r_cnt <= '0;
        S_RUN: begin
          if (w_advance) r_cnt <= r_cnt + SIZE_W'(1);
        end
        S_RELEASE: begin
          if (r_ch != c_last_ch) begin
            r_ch  <= r_ch + CH_W'(1);
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
      if (r_state != S_IDLE && r_cycles != c_cyc_max) r_cycles <= r_cycles + CYC_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    fe_start = 1'b0;
    fe_zero  = 1'b0;
    fe_last  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    addr     = w_addr_sum;
    ch_sel   = r_ch;
    case (r_state)
      S_IDLE: begin
        busy   = 1'b0;
        addr   = '0;
        ch_sel = '0;
        if (start) w_next = S_LOAD;
      end
      S_LOAD:  w_next = S_ISSUE;
      S_ISSUE: begin
        fe_start = 1'b1;
        fe_zero  = (w_size_cur == '0);
        w_next   = S_RUN;
      end
      S_RUN: begin
        fe_last = w_at_end;
        if (fe_done) w_next = S_RELEASE;
      end
      // Dropping last for a cycle is what lets the front_end leave DONE.
      S_RELEASE: w_next = (r_ch == c_last_ch) ? S_FINISH : S_LOAD;
      S_FINISH: begin
        done   = 1'b1;
        addr   = '0;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_front_end_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mm_front_end_sequencer: directed runs compared cycle by cycle against   |
// | an expected-trace model built from per-channel base/size and stall plans.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mm_front_end_sequencer;

  localparam int N_CH   = 2;
  localparam int ADDR_W = 12;
  localparam int SIZE_W = 12;
  localparam int CYC_W  = 32;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic                   start;
  logic [N_CH*ADDR_W-1:0] base;
  logic [N_CH*SIZE_W-1:0] size;
  logic                   fe_en;
  logic                   fe_done;
  logic                   fe_start;
  logic                   fe_zero;
  logic                   fe_last;
  logic [ADDR_W-1:0]      addr;
  logic [0:0]             ch_sel;
  logic                   busy;
  logic                   done;
  logic [CYC_W-1:0]       cycles;

  mm_front_end_sequencer #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .CYC_W(CYC_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .base(base), .size(size),
    .fe_en(fe_en), .fe_done(fe_done), .fe_start(fe_start), .fe_zero(fe_zero),
    .fe_last(fe_last), .addr(addr), .ch_sel(ch_sel), .busy(busy), .done(done),
    .cycles(cycles)
  );

  always #5 aclk = ~aclk;

  // One entry per clock: stimulus to apply plus the outputs that cycle must show.
  typedef struct packed {
    logic        start, en, fdone, run;
    logic        busy, dn, fs, fz, fl, ch;
    logic [11:0] addr;
    logic [31:0] cyc;
  } rec_t;

  rec_t        q[$];
  int unsigned m_cyc;
  int          nchk = 0;
  int          nerr = 0;
  int          n_fs, n_dn;

  function automatic rec_t mk(input bit bsy, input bit dn, input bit fs, input bit fz,
                              input bit fl, input int ch, input int a, input bit en,
                              input bit fd, input bit st, input bit run);
    rec_t r;
    int   aa;
    aa      = a;
    r       = '0;
    r.busy  = bsy;  r.dn = dn;  r.fs = fs;  r.fz = fz;  r.fl = fl;
    r.ch    = ch[0];
    r.addr  = aa[11:0];
    r.en    = en;   r.fdone = fd;  r.start = st;  r.run = run;
    return r;
  endfunction

  task automatic push(input rec_t r);
    r.cyc = m_cyc;
    q.push_back(r);
    if (r.busy) m_cyc++;
    else if (r.start) m_cyc = 0;
  endtask

  // Expected trace for one full run; front_end reports done one cycle after last.
  task automatic build(input int b0, input int b1, input int s0, input int s1,
                       input int stc, input int sti, input int stn, input bit inj);
    int bb[2];
    int ss[2];
    bb[0] = b0; bb[1] = b1; ss[0] = s0; ss[1] = s1;
    q.delete();
    push(mk(0,0,0,0,0,0,0, 0,0,1,0));
    for (int c = 0; c < 2; c++) begin
      push(mk(1,0,0,0,0,c,bb[c], 0,inj,0,0));
      push(mk(1,0,1,(ss[c]==0),0,c,bb[c], 0,0,0,0));
      if (ss[c] == 0) begin
        push(mk(1,0,0,0,0,c,bb[c], 0,1,0,1));
      end else begin
        for (int i = 0; i < ss[c]-1; i++) begin
          if (c == stc && i == sti)
            for (int k = 0; k < stn; k++) push(mk(1,0,0,0,0,c,bb[c]+i, 0,0,0,1));
          push(mk(1,0,0,0,0,c,bb[c]+i, 1,0,(inj && i==0),1));
        end
        push(mk(1,0,0,0,1,c,bb[c]+ss[c]-1, inj,0,0,1));
        push(mk(1,0,0,0,1,c,bb[c]+ss[c]-1, 0,1,0,1));
      end
      push(mk(1,0,0,0,0,c,bb[c]+((ss[c]==0) ? 0 : ss[c]-1), 0,inj,0,0));
    end
    push(mk(1,1,0,0,0,1,0, 0,inj,0,0));
    push(mk(0,0,0,0,0,0,0, 0,inj,0,0));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rec(input rec_t r);
    chk("busy",     32'(busy),     32'(r.busy));
    chk("done",     32'(done),     32'(r.dn));
    chk("fe_start", 32'(fe_start), 32'(r.fs));
    chk("fe_zero",  32'(fe_zero),  32'(r.fz));
    chk("fe_last",  32'(fe_last),  32'(r.fl));
    chk("ch_sel",   32'(ch_sel),   32'(r.ch));
    chk("addr",     32'(addr),     32'(r.addr));
    chk("cycles",   cycles,        r.cyc);
    n_fs += int'(fe_start);
    n_dn += int'(done);
  endtask

  task automatic set_cfg(input int b0, input int b1, input int s0, input int s1);
    logic [11:0] x0, x1, y0, y1;
    x0 = 12'(b0); x1 = 12'(b1); y0 = 12'(s0); y1 = 12'(s1);
    base = {x1, x0};
    size = {y1, y0};
  endtask

  // Walks the trace; at index stop_k it checks then asserts reset instead.
  task automatic exec(input int stop_k);
    bit stopped;
    stopped = 0;
    n_fs = 0;
    n_dn = 0;
    for (int i = 0; i < q.size() && !stopped; i++) begin
      @(posedge aclk); #1;
      chk_rec(q[i]);
      if (i == stop_k) begin
        aresetn = 1'b0; start = 1'b0; fe_en = 1'b0; fe_done = 1'b0;
        stopped = 1;
      end else begin
        start = q[i].start; fe_en = q[i].en; fe_done = q[i].fdone;
        if (i == 1) begin
          base = ~base;
          size = ~size;
        end
      end
    end
  endtask

  initial begin
    int stop_k;
    rec_t z;
    aresetn = 1'b0; start = 1'b0; fe_en = 1'b0; fe_done = 1'b0;
    base = '0; size = '0; m_cyc = 0;
    repeat (2) @(posedge aclk);
    #1;
    z = '0;
    chk_rec(z);
    aresetn = 1'b1;

    // Clean two-channel run: ch0 0x000 x4, ch1 0x100 x3.
    set_cfg(12'h000, 12'h100, 4, 3);
    build(12'h000, 12'h100, 4, 3, -1, -1, 0, 0);
    exec(-1);
    chk("clean_cycles", cycles, 32'd16);
    chk("clean_fe_start_pulses", 32'(n_fs), 32'd2);
    chk("clean_done_pulses", 32'(n_dn), 32'd1);

    // Zero-length first channel.
    set_cfg(12'h020, 12'h300, 0, 5);
    build(12'h020, 12'h300, 0, 5, -1, -1, 0, 0);
    exec(-1);
    chk("zero_cycles", cycles, 32'd14);
    chk("zero_done_pulses", 32'(n_dn), 32'd1);

    // Address wrap past 0xFFF.
    set_cfg(12'hFFE, 12'h010, 4, 1);
    build(12'hFFE, 12'h010, 4, 1, -1, -1, 0, 0);
    exec(-1);
    chk("wrap_cycles", cycles, 32'd14);

    // Ten-cycle stall inside ch0.
    set_cfg(12'h000, 12'h100, 4, 3);
    build(12'h000, 12'h100, 4, 3, 0, 1, 10, 0);
    exec(-1);
    chk("stall_cycles", cycles, 32'd26);

    // Spurious start in RUN, spurious fe_done outside RUN, en while last.
    set_cfg(12'h000, 12'h100, 4, 3);
    build(12'h000, 12'h100, 4, 3, -1, -1, 0, 1);
    exec(-1);
    chk("inject_cycles", cycles, 32'd16);
    chk("inject_fe_start_pulses", 32'(n_fs), 32'd2);
    chk("inject_done_pulses", 32'(n_dn), 32'd1);

    // Reset during ch1 RUN, then a fresh run.
    set_cfg(12'h000, 12'h100, 4, 3);
    build(12'h000, 12'h100, 4, 3, -1, -1, 0, 0);
    stop_k = -1;
    for (int i = 0; i < q.size(); i++)
      if (stop_k < 0 && q[i].ch && q[i].run && q[i].en) stop_k = i;
    chk("reset_point_found", 32'(stop_k > 0), 32'd1);
    exec(stop_k);
    @(posedge aclk); #1;
    z = '0;
    chk_rec(z);
    aresetn = 1'b1;
    m_cyc = 0;
    set_cfg(12'h000, 12'h100, 4, 3);
    build(12'h000, 12'h100, 4, 3, -1, -1, 0, 0);
    exec(-1);
    chk("post_reset_cycles", cycles, 32'd16);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
